// File: rtl/seq_shr_pkg.sv
// rtl/seq_shr_pkg.sv - shared state encoding and width helpers for the serial right shifter
package seq_shr_pkg;

   localparam int DEFAULT_DATAWIDTH = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Width needed to hold any count from 0 up to and including dw.
   function automatic int cnt_width(input int dw);
      return $clog2(dw + 1);
   endfunction

endpackage

// File: rtl/seq_shr_if.sv
// rtl/seq_shr_if.sv - request/result bundle between a requester and the serial right shifter
interface seq_shr_if
   import seq_shr_pkg::*;
#(
   parameter int DATAWIDTH = DEFAULT_DATAWIDTH
);
   logic                 start;
   logic [DATAWIDTH-1:0] a;
   logic [DATAWIDTH-1:0] sh_amt;
   logic                 arith;
   logic [DATAWIDTH-1:0] d;
   logic                 busy;
   logic                 done;

   modport master (
      output start, a, sh_amt, arith,
      input  d, busy, done
   );

   modport slave (
      input  start, a, sh_amt, arith,
      output d, busy, done
   );

endinterface

// File: rtl/seq_shr.sv
// rtl/seq_shr.sv - one-bit-per-cycle right shifter with logical/arithmetic fill and saturation
module seq_shr
   import seq_shr_pkg::*;
#(
   parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
   input  logic      clk,
   input  logic      rst,
   seq_shr_if.slave  bus
);

   localparam int CW = cnt_width(DATAWIDTH);
   localparam logic [DATAWIDTH-1:0] DW_FULL = DATAWIDTH'(DATAWIDTH);

   state_t               state;
   logic [CW-1:0]        count;
   logic [DATAWIDTH-1:0] sr;
   logic                 arith_q;
   logic [DATAWIDTH-1:0] d_q;
   logic                 done_q;

   // Amounts at or beyond the width all behave like a full-width shift;
   // compare on every bit of sh_amt so large values never alias to small ones.
   logic                 sat;
   logic [CW-1:0]        load_count;
   logic                 fill;

   // Load value for the counter and the bit shifted in at the top.
   always_comb begin
      sat        = (bus.sh_amt >= DW_FULL);
      load_count = sat ? CW'(DATAWIDTH) : bus.sh_amt[CW-1:0];
      // Arithmetic fill replicates the current MSB, which stays the sign bit.
      fill       = arith_q & sr[DATAWIDTH-1];
   end

   // Two-state controller: accept in IDLE, shift one bit per cycle, publish on count==0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         sr      <= '0;
         arith_q <= 1'b0;
         d_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sr      <= bus.a;
                  count   <= load_count;
                  arith_q <= bus.arith;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (count != '0) begin
                  sr    <= {fill, sr[DATAWIDTH-1:1]};
                  count <= count - CW'(1);
               end else begin
                  d_q    <= sr;
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.d    = d_q;
   assign bus.done = done_q;
   assign bus.busy = (state == SHIFT);

endmodule

// File: tb/tb_seq_shr.sv
// tb/tb_seq_shr.sv - self-checking bench for seq_shr
module tb_seq_shr;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   seq_shr_if #(.DATAWIDTH(16)) bus ();

   seq_shr #(.DATAWIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] sh;
      logic        ar;
      logic [15:0] exp_d;
      int          exp_lat;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Result of shifting a right by sh with sign or zero fill, treating any
   // amount of 16 or more as a full-width shift.
   function automatic logic [15:0] model_d(input logic [15:0] a, input logic [15:0] sh, input logic ar);
      int unsigned n;
      logic [31:0] v;
      n = (sh >= 16'd16) ? 16 : int'(sh);
      v = ar ? {{16{a[15]}}, a} : {16'h0000, a};
      v = v >> n;
      return v[15:0];
   endfunction

   function automatic int model_lat(input logic [15:0] sh);
      return ((sh >= 16'd16) ? 16 : int'(sh)) + 1;
   endfunction

   // Issue one request from an idle state, optionally pulse start again while
   // busy (at loop index glitch), and wait for done. Called #1 after an edge.
   task automatic run_op(input logic [15:0] a, input logic [15:0] sh, input logic ar,
                         input int glitch, output logic [15:0] d_out,
                         output int lat, output int bc);
      bus.start  = 1'b1;
      bus.a      = a;
      bus.sh_amt = sh;
      bus.arith  = ar;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.a      = 16'($urandom);
      bus.sh_amt = 16'($urandom);
      bus.arith  = 1'($urandom);
      lat = 0;
      bc  = bus.busy ? 1 : 0;
      while (lat < 100) begin
         if (lat == glitch) begin
            bus.start  = 1'b1;
            bus.a      = 16'hFFFF;
            bus.sh_amt = 16'h0000;
         end else begin
            bus.start  = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
         if (bus.done) break;
         if (bus.busy) bc++;
      end
      bus.start = 1'b0;
      d_out = bus.d;
      if (!bus.done) begin
         chk("done_timeout", 32'd0, 32'd1);
         lat = -1;
      end
   endtask

   task automatic apply(input string name, input logic [15:0] a, input logic [15:0] sh,
                        input logic ar, input logic [15:0] exp_d, input int exp_lat,
                        input int glitch);
      logic [15:0] d_got;
      int lat;
      int bc;
      run_op(a, sh, ar, glitch, d_got, lat, bc);
      chk({name, "_d"}, 32'(d_got), 32'(exp_d));
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({name, "_busy_cycles"}, 32'(bc), 32'(exp_lat));
      // One cycle later: done must drop and d must hold.
      @(posedge clk); #1;
      chk({name, "_done_pulse"}, 32'(bus.done), 32'd0);
      chk({name, "_d_hold"}, 32'(bus.d), 32'(exp_d));
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rsh;
      logic        rar;
      int          lat;
      int          done_seen;

      tests = 0;
      fails = 0;

      vecs[0] = '{16'hF0F0, 16'd4,      1'b0, 16'h0F0F, 5};
      vecs[1] = '{16'h8000, 16'd3,      1'b1, 16'hF000, 4};
      vecs[2] = '{16'h8000, 16'd3,      1'b0, 16'h1000, 4};
      vecs[3] = '{16'h1234, 16'd0,      1'b0, 16'h1234, 1};
      vecs[4] = '{16'h8001, 16'h0100,   1'b1, 16'hFFFF, 17};
      vecs[5] = '{16'h8001, 16'h0100,   1'b0, 16'h0000, 17};
      vecs[6] = '{16'hFFFF, 16'd15,     1'b0, 16'h0001, 16};
      vecs[7] = '{16'h8000, 16'd16,     1'b1, 16'hFFFF, 17};
      vecs[8] = '{16'h7FFF, 16'hFFFF,   1'b1, 16'h0000, 17};

      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.a      = '0;
      bus.sh_amt = '0;
      bus.arith  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_d", 32'(bus.d), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i])
         apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].sh, vecs[i].ar,
               vecs[i].exp_d, vecs[i].exp_lat, -1);

      // start with a different operand while busy must not disturb the result.
      apply("busy_ignore", 16'hF0F0, 16'd4, 1'b0, 16'h0F0F, 5, 1);
      chk("busy_ignore_idle", 32'(bus.busy), 32'd0);

      // start held high through done: second request accepted on the done cycle.
      bus.start  = 1'b1;
      bus.a      = 16'h00F0;
      bus.sh_amt = 16'd4;
      bus.arith  = 1'b0;
      @(posedge clk); #1;
      bus.a      = 16'h8000;
      bus.sh_amt = 16'd1;
      bus.arith  = 1'b1;
      lat = 0;
      while (lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (bus.done) break;
      end
      chk("b2b_first_d", 32'(bus.d), 32'h000F);
      chk("b2b_first_lat", 32'(lat), 32'd5);
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("b2b_second_accepted", 32'(bus.busy), 32'd1);
      lat = 0;
      while (lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (bus.done) break;
      end
      chk("b2b_second_d", 32'(bus.d), 32'hC000);
      chk("b2b_second_lat", 32'(lat), 32'd2);
      @(posedge clk); #1;

      // Reset at cycle 3 of an 8-bit shift aborts it without a done pulse.
      done_seen = 0;
      bus.start  = 1'b1;
      bus.a      = 16'h00AB;
      bus.sh_amt = 16'd8;
      bus.arith  = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.done) done_seen++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_d", 32'(bus.d), 32'd0);
      chk("rst_mid_busy", 32'(bus.busy), 32'd0);
      if (bus.done) done_seen++;
      rst = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus.done) done_seen++;
      end
      chk("rst_mid_no_done", 32'(done_seen), 32'd0);

      apply("post_reset", 16'h00AB, 16'd8, 1'b0, 16'h0000, 9, -1);

      for (int k = 0; k < 150; k++) begin
         ra  = 16'($urandom);
         rar = 1'($urandom);
         if ($urandom_range(0, 3) == 0) rsh = 16'($urandom);
         else rsh = 16'($urandom_range(0, 20));
         apply($sformatf("rand%0d", k), ra, rsh, rar, model_d(ra, rsh, rar), model_lat(rsh), -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_shr.md
SEQ_SHR -- requirements
Module: seq_shr

Interface
REQ-001 Parameter DATAWIDTH, default 16, SHALL set the operand, shift-amount and result width.
REQ-002 Clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 Rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request a shift; it is sampled only in IDLE.
REQ-005 a  input  DATAWIDTH  SHALL be the operand, captured on the accepting edge.
REQ-006 sh_amt  input  DATAWIDTH  SHALL be the unsigned shift amount, captured on the accepting edge.
REQ-007 arith  input  1  SHALL select the fill bit, captured on the accepting edge: 1 = sign fill (arithmetic), 0 = zero fill (logical).
REQ-008 d  output  DATAWIDTH  SHALL be the registered result of the last completed shift.
REQ-009 busy  output  1  SHALL be high while a shift is in progress (state SHIFT).
REQ-010 done  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-012 In IDLE with start=1, on that edge the block SHALL load an internal register with a, load count with min(sh_amt, DATAWIDTH), latch arith, and enter SHIFT.
REQ-013 In SHIFT with count>0, each edge SHALL shift the register right by one bit, fill the MSB with the latched fill bit, and decrement count.
REQ-014 In SHIFT with count=0, the edge SHALL copy the register to d, assert done for one cycle, and return to IDLE.
REQ-015 Latency SHALL be min(sh_amt, DATAWIDTH)+1 cycles from the accepting edge to the edge that raises done.
REQ-016 When sh_amt=0, the block SHALL return d=a one cycle after acceptance.
REQ-017 When sh_amt>=DATAWIDTH (including values above 255), the block SHALL saturate: d = all zeros (logical), or all copies of a[DATAWIDTH-1] (arithmetic).
REQ-018 The count register SHALL be clog2(DATAWIDTH+1) bits wide.
REQ-019 The saturation compare SHALL use the full sh_amt width, so upper bits are never truncated.
REQ-020 start while busy=1 SHALL be ignored, with no queuing.
REQ-021 Inputs a, sh_amt and arith SHALL be don't-care after acceptance.
REQ-022 start may be high in the cycle done is high; because the FSM is then in IDLE, the request SHALL be accepted, giving back-to-back operation.
REQ-023 d SHALL hold its value between completions and change only on the completion edge.
REQ-024 busy SHALL be a pure function of state; done SHALL be registered.

Reset
REQ-025 Rst=1 SHALL force, on the next edge: state=IDLE, d=0, done=0, busy=0, count=0, internal register=0.
REQ-026 Rst SHALL take priority over start and over an in-progress shift.
REQ-027 A reset mid-operation SHALL abort the operation with no done pulse.
REQ-028 The first start after Rst deasserts SHALL be accepted normally.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=1'b0, SHIFT=1'b1) and the count-width function/constant derived from DATAWIDTH.
REQ-030 The block SHALL be a single module with no sub-module; the FSM, counter and shift register are small enough to sit together.
REQ-031 Parameterisation SHALL be by DATAWIDTH only, with no other hardcoded widths.

Verification
REQ-032 Logical shift: a=16'hF0F0, sh_amt=4, arith=0 -> done on the 5th edge after acceptance, d=16'h0F0F, busy high for exactly 5 cycles.
REQ-033 Arithmetic shift: a=16'h8000, sh_amt=3, arith=1 -> d=16'hF000; repeat with arith=0 -> d=16'h1000.
REQ-034 Boundaries:
- sh_amt=0, a=16'h1234 -> d=16'h1234 with 1-cycle latency.
- sh_amt=16'h0100, a=16'h8001, arith=1 -> d=16'hFFFF after 17 cycles.
- same with arith=0 -> d=16'h0000.
REQ-035 Busy ignore and back-to-back:
- start pulsed during SHIFT with different a -> ignored, and the first result is unchanged.
- start held high through done -> second operation accepted on the done cycle.
REQ-036 Reset mid-shift: assert Rst at cycle 3 of an 8-bit shift -> next edge d=0, busy=0, and no done pulse ever appears for the aborted operation.
